// File: rtl/nlc_horner_sequencer_if.sv
// Arithmetic-port interface between the NLC Horner sequencer (master) and the
// shared external arithmetic units (slave: fp_to_smc, smc_float mul/add,
// smc_to_fp).
//
// Signals:
//   op_code_o  [1:0]   operation select: 00 fp_to_smc, 01 mul, 10 add, 11 smc_to_fp
//   op_a_o     [FW-1:0] operand A
//   op_b_o     [FW-1:0] operand B (0 for conversions)
//   op_srdyi_o          issue strobe, master -> slave
//   op_z_i     [FW-1:0] result, slave -> master
//   op_srdyo_i          result-valid strobe, slave -> master
//
// Handshake: op_srdyi_o is high for exactly one cycle per operation and there
// is no backpressure. op_code_o/op_a_o/op_b_o are valid in the strobe cycle
// and are held unchanged until the cycle in which op_srdyo_i is sampled high.
// The slave answers every issue with exactly one single-cycle op_srdyo_i,
// L >= 1 cycles later, with op_z_i valid in that same cycle. At most one
// operation is outstanding; op_srdyo_i with nothing outstanding is ignored.
interface nlc_horner_sequencer_if #(
  parameter int FW = 32
);
  logic [1:0]    op_code_o;
  logic [FW-1:0] op_a_o;
  logic [FW-1:0] op_b_o;
  logic          op_srdyi_o;
  logic [FW-1:0] op_z_i;
  logic          op_srdyo_i;

  modport master (
    output op_code_o, op_a_o, op_b_o, op_srdyi_o,
    input  op_z_i, op_srdyo_i
  );

  modport slave (
    input  op_code_o, op_a_o, op_b_o, op_srdyi_o,
    output op_z_i, op_srdyo_i
  );
endinterface

// File: rtl/nlc_horner_sequencer.sv
// Time-multiplexed nonlinearity-correction engine. A frame of NUM_CH channels
// is captured on srdyi; for each channel the polynomial of order ORDER is
// evaluated in Horner form through one shared external arithmetic port,
// one operation at a time (4 + 2*ORDER operations per channel).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   srdyi           frame valid; captures all channel inputs when idle
//   srdyo           one-cycle pulse: all x_lin_o slices valid
//   busy_o          frame in progress
//   overrun_o       sticky: srdyi seen while not idle (cleared by reset only)
//   x_adc_i         raw samples, channel c at [c*XW +: XW]
//   recip_stdev_i   per-channel scale, channel c at [c*FW +: FW]
//   neg_mean_i      per-channel offset, channel c at [c*FW +: FW]
//   coeff_i         coeff k of channel c at [(c*(ORDER+1)+k)*FW +: FW]
//   x_lin_o         linearised results, channel c at [c*XW +: XW]
//   dbg_state_o     FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
//   op_if           arithmetic port (master side)
module nlc_horner_sequencer #(
  parameter int NUM_CH = 16,
  parameter int ORDER  = 5,
  parameter int XW     = 21,
  parameter int FW     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          srdyi,
  output logic                          srdyo,
  output logic                          busy_o,
  output logic                          overrun_o,
  input  logic [NUM_CH*XW-1:0]          x_adc_i,
  input  logic [NUM_CH*FW-1:0]          recip_stdev_i,
  input  logic [NUM_CH*FW-1:0]          neg_mean_i,
  input  logic [NUM_CH*(ORDER+1)*FW-1:0] coeff_i,
  output logic [NUM_CH*XW-1:0]          x_lin_o,
  output logic [1:0]                    dbg_state_o,
  nlc_horner_sequencer_if.master        op_if
);
  localparam int STEPS = 4 + 2 * ORDER;
  localparam int SW    = $clog2(STEPS);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NC    = ORDER + 1;

  localparam logic [1:0] OP_FP2SMC = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_SMC2FP = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [SW-1:0]   step_q, step_d;

  // Frame buffer: inputs are sampled once per frame so the source may change
  // freely while the frame is being processed.
  logic [NUM_CH*XW-1:0]           x_buf_q;
  logic [NUM_CH*FW-1:0]           rs_buf_q;
  logic [NUM_CH*FW-1:0]           nm_buf_q;
  logic [NUM_CH*NC*FW-1:0]        cf_buf_q;

  logic [FW-1:0]        xs_q, t_q, acc_q;
  logic                 overrun_q;
  logic [NUM_CH*XW-1:0] x_lin_q;

  logic          capture, op_done, last_step, last_ch;
  logic [1:0]    op_code;
  logic [FW-1:0] op_a, op_b, xz;
  int            ch_i, step_i, j_i, k_i;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    step_d    = step_q;
    capture   = 1'b0;
    op_done   = 1'b0;
    last_step = (step_q == SW'(STEPS - 1));
    last_ch   = (ch_q == CW'(NUM_CH - 1));
    case (state_q)
      IDLE: begin
        if (srdyi) begin
          capture = 1'b1;
          state_d = ISSUE;
          ch_d    = '0;
          step_d  = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (op_if.op_srdyo_i) begin
          op_done = 1'b1;
          if (last_step) begin
            step_d = '0;
            if (last_ch) begin
              ch_d    = '0;
              state_d = DONE;
            end else begin
              ch_d    = ch_q + CW'(1);
              state_d = ISSUE;
            end
          end else begin
            step_d  = step_q + SW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand selection. Purely a function of step/channel and registers that
  // only change on op completion, so operands stay stable through WAIT.
  // Horner steps from 3 on alternate: even j -> acc*t, odd j -> acc+coeff[k],
  // with k walking from ORDER-1 down to 0.
  always_comb begin
    ch_i    = int'(ch_q);
    step_i  = int'(step_q);
    j_i     = 0;
    k_i     = 0;
    xz      = '0;
    xz[XW-1:0] = x_buf_q[ch_i*XW +: XW];
    op_code = OP_FP2SMC;
    op_a    = '0;
    op_b    = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      if (step_i == 0) begin
        op_code = OP_FP2SMC;
        op_a    = xz;
      end else if (step_i == 1) begin
        op_code = OP_ADD;
        op_a    = xs_q;
        op_b    = nm_buf_q[ch_i*FW +: FW];
      end else if (step_i == 2) begin
        op_code = OP_MUL;
        op_a    = t_q;
        op_b    = rs_buf_q[ch_i*FW +: FW];
      end else if (step_i == STEPS - 1) begin
        op_code = OP_SMC2FP;
        op_a    = acc_q;
      end else begin
        j_i = step_i - 3;
        k_i = ORDER - 1 - (j_i / 2);
        if (!j_i[0]) begin
          op_code = OP_MUL;
          op_a    = acc_q;
          op_b    = t_q;
        end else begin
          op_code = OP_ADD;
          op_a    = acc_q;
          op_b    = cf_buf_q[(ch_i*NC + k_i)*FW +: FW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      step_q    <= '0;
      xs_q      <= '0;
      t_q       <= '0;
      acc_q     <= '0;
      overrun_q <= 1'b0;
      x_lin_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      step_q  <= step_d;
      if (srdyi && state_q != IDLE) overrun_q <= 1'b1;
      if (op_done) begin
        if (step_q == '0) begin
          xs_q <= op_if.op_z_i;
        end else if (step_q == SW'(1)) begin
          t_q <= op_if.op_z_i;
        end else if (step_q == SW'(2)) begin
          // Horner accumulator seeds with the highest-order coefficient.
          t_q   <= op_if.op_z_i;
          acc_q <= cf_buf_q[(ch_i*NC + ORDER)*FW +: FW];
        end else if (last_step) begin
          x_lin_q[ch_i*XW +: XW] <= op_if.op_z_i[XW-1:0];
        end else begin
          acc_q <= op_if.op_z_i;
        end
      end
    end
  end

  // Buffer has no reset; reset only has to stop a capture in the same cycle.
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      x_buf_q  <= x_adc_i;
      rs_buf_q <= recip_stdev_i;
      nm_buf_q <= neg_mean_i;
      cf_buf_q <= coeff_i;
    end
  end

  assign op_if.op_code_o  = op_code;
  assign op_if.op_a_o     = op_a;
  assign op_if.op_b_o     = op_b;
  assign op_if.op_srdyi_o = (state_q == ISSUE);
  assign srdyo            = (state_q == DONE);
  assign busy_o           = (state_q == ISSUE) || (state_q == WAIT);
  assign overrun_o        = overrun_q;
  assign x_lin_o          = x_lin_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_nlc_horner_sequencer.sv
// Bench for nlc_horner_sequencer. Two instances: a small one (2 channels,
// order 1) with a mock arithmetic unit of selectable latency, and a default
// one (16 channels, order 5) with a fixed-latency-3 mock. Mocks use integer
// semantics: conversions are identity, add is sum, mul is low-32 product.
// Edge numbering: the edge that captures srdyi is edge 0; an output seen
// between edges n-1 and n is reported as cycle n.
module tb_nlc_horner_sequencer;
  localparam int XW    = 21;
  localparam int FW    = 32;
  localparam int A_CH  = 2;
  localparam int A_ORD = 1;
  localparam int B_CH  = 16;
  localparam int B_ORD = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b;

  // ---------------- DUT A (2 ch, order 1) ----------------
  logic srdyi_a, srdyo_a, busy_a, ovr_a;
  logic [1:0] st_a;
  logic [A_CH*XW-1:0] x_a, xl_a;
  logic [A_CH*FW-1:0] rs_a, nm_a;
  logic [A_CH*(A_ORD+1)*FW-1:0] cf_a;
  nlc_horner_sequencer_if #(.FW(FW)) ifa();

  nlc_horner_sequencer #(.NUM_CH(A_CH), .ORDER(A_ORD), .XW(XW), .FW(FW)) dut_a (
    .clk(clk), .reset(rst_a), .srdyi(srdyi_a), .srdyo(srdyo_a), .busy_o(busy_a),
    .overrun_o(ovr_a), .x_adc_i(x_a), .recip_stdev_i(rs_a), .neg_mean_i(nm_a),
    .coeff_i(cf_a), .x_lin_o(xl_a), .dbg_state_o(st_a), .op_if(ifa)
  );

  // ---------------- DUT B (defaults) ----------------
  logic srdyi_b, srdyo_b, busy_b, ovr_b;
  logic [1:0] st_b;
  logic [B_CH*XW-1:0] x_b, xl_b;
  logic [B_CH*FW-1:0] rs_b, nm_b;
  logic [B_CH*(B_ORD+1)*FW-1:0] cf_b;
  nlc_horner_sequencer_if #(.FW(FW)) ifb();

  nlc_horner_sequencer dut_b (
    .clk(clk), .reset(rst_b), .srdyi(srdyi_b), .srdyo(srdyo_b), .busy_o(busy_b),
    .overrun_o(ovr_b), .x_adc_i(x_b), .recip_stdev_i(rs_b), .neg_mean_i(nm_b),
    .coeff_i(cf_b), .x_lin_o(xl_b), .dbg_state_o(st_b), .op_if(ifb)
  );

  // ---------------- mock arithmetic units ----------------
  function automatic logic [FW-1:0] mock_calc(input logic [1:0] c, input logic [FW-1:0] a,
                                              input logic [FW-1:0] b);
    case (c)
      2'b01:   return a * b;
      2'b10:   return a + b;
      default: return a;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 5;
      2:       return 2;
      default: return 7;
    endcase
  endfunction

  function automatic logic [1:0] exp_code(input int s);
    if (s == 0) return 2'b00;
    if (s == 1) return 2'b10;
    if (s == 2) return 2'b01;
    if (s == 4 + 2*B_ORD - 1) return 2'b11;
    return (((s - 3) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  logic mock_srdyo_a = 1'b0, spur_a = 1'b0;
  logic [FW-1:0] mock_z_a = '0, res_a = '0, held_a_a = '0, held_b_a = '0;
  logic [1:0] held_c_a = '0;
  int cnt_a = 0, pat_a = 0, lat_mode_a = 0, stab_err_a = 0, srdyo_cnt_a = 0;
  assign ifa.op_srdyo_i = mock_srdyo_a | spur_a;
  assign ifa.op_z_i     = mock_z_a;

  // Sees an issue between edges, answers so the DUT samples the result L edges later.
  always @(negedge clk) begin
    mock_srdyo_a = 1'b0;
    if (srdyo_a) srdyo_cnt_a++;
    if (rst_a) begin
      cnt_a = 0;
    end else if (cnt_a > 0) begin
      if (ifa.op_code_o !== held_c_a || ifa.op_a_o !== held_a_a || ifa.op_b_o !== held_b_a)
        stab_err_a++;
      cnt_a--;
      if (cnt_a == 0) begin
        mock_srdyo_a = 1'b1;
        mock_z_a     = res_a;
      end
    end
    if (ifa.op_srdyi_o) begin
      held_c_a = ifa.op_code_o;
      held_a_a = ifa.op_a_o;
      held_b_a = ifa.op_b_o;
      res_a    = mock_calc(ifa.op_code_o, ifa.op_a_o, ifa.op_b_o);
      cnt_a    = (lat_mode_a == 0) ? 1 : lat_of(pat_a % 4);
      pat_a++;
    end
  end

  logic mock_srdyo_b = 1'b0;
  logic [FW-1:0] mock_z_b = '0, res_b = '0;
  int cnt_b = 0, issue_cnt_b = 0, code_err_b = 0, srdyo_cnt_b = 0;
  assign ifb.op_srdyo_i = mock_srdyo_b;
  assign ifb.op_z_i     = mock_z_b;

  always @(negedge clk) begin
    mock_srdyo_b = 1'b0;
    if (srdyo_b) srdyo_cnt_b++;
    if (rst_b) begin
      cnt_b = 0;
    end else if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin
        mock_srdyo_b = 1'b1;
        mock_z_b     = res_b;
      end
    end
    if (ifb.op_srdyi_o) begin
      if (ifb.op_code_o !== exp_code(issue_cnt_b % (4 + 2*B_ORD))) code_err_b++;
      issue_cnt_b++;
      res_b = mock_calc(ifb.op_code_o, ifb.op_a_o, ifb.op_b_o);
      cnt_b = 3;
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch_a(input int c, input int x, input int nm, input int rs,
                          input int c1, input int c0);
    x_a[c*XW +: XW]               = XW'(x);
    nm_a[c*FW +: FW]              = FW'(nm);
    rs_a[c*FW +: FW]              = FW'(rs);
    cf_a[(c*(A_ORD+1)+1)*FW +: FW] = FW'(c1);
    cf_a[(c*(A_ORD+1)+0)*FW +: FW] = FW'(c0);
  endtask

  task automatic start_frame_a(output int cap);
    @(negedge clk);
    srdyi_a = 1'b1;
    cap = cyc + 1;
    @(negedge clk);
    srdyi_a = 1'b0;
  endtask

  // Returns at the negedge where srdyo is seen; edge_at = -1 on timeout.
  task automatic wait_srdyo_a(input int budget, output int edge_at);
    edge_at = -1;
    for (int i = 0; i < budget; i++) begin
      if (srdyo_a) begin
        edge_at = cyc + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_srdyo"},   srdyo_a, 0);
    check_eq({tag, "_busy"},    busy_a, 0);
    check_eq({tag, "_overrun"}, ovr_a, 0);
    check_eq({tag, "_op_srdyi"}, ifa.op_srdyi_o, 0);
    check_eq({tag, "_op_code"}, ifa.op_code_o, 0);
    check_eq({tag, "_op_a"},    ifa.op_a_o, 0);
    check_eq({tag, "_op_b"},    ifa.op_b_o, 0);
    check_eq({tag, "_x_lin"},   xl_a, 0);
    check_eq({tag, "_state"},   st_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cap, edge_at, cs, ib, found;
    rst_a = 1'b1; rst_b = 1'b1; srdyi_a = 1'b0; srdyi_b = 1'b0;
    x_a = '0; rs_a = '0; nm_a = '0; cf_a = '0;
    x_b = '0; rs_b = '0; nm_b = '0; cf_b = '0;
    repeat (3) @(negedge clk);
    check_reset_a("rst");
    check_eq("rst_b_busy", busy_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Test 2: defaults, L=3. x=2, nm=0, rs=1, c5=1, c0=ch, rest 0 -> 32+ch.
    for (int c = 0; c < B_CH; c++) begin
      x_b[c*XW +: XW]  = XW'(2);
      nm_b[c*FW +: FW] = '0;
      rs_b[c*FW +: FW] = FW'(1);
      cf_b[(c*(B_ORD+1)+B_ORD)*FW +: FW] = FW'(1);
      cf_b[(c*(B_ORD+1)+0)*FW +: FW]     = FW'(c);
    end
    cs = srdyo_cnt_b; ib = issue_cnt_b;
    @(negedge clk);
    srdyi_b = 1'b1;
    cap = cyc + 1;
    @(negedge clk);
    srdyi_b = 1'b0;
    check_eq("b_busy_rise", busy_b, 1);
    edge_at = -1;
    for (int i = 0; i < 1200; i++) begin
      if (srdyo_b) begin
        edge_at = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("b_srdyo_cycle", 64'(edge_at - cap), 897);
    repeat (5) @(negedge clk);
    check_eq("b_srdyo_count", 64'(srdyo_cnt_b - cs), 1);
    check_eq("b_issue_count", 64'(issue_cnt_b - ib), 224);
    check_eq("b_opcode_seq_err", 64'(code_err_b), 0);
    check_eq("b_xlin_ch0", xl_b[0*XW +: XW], 32);
    check_eq("b_xlin_ch7", xl_b[7*XW +: XW], 39);
    check_eq("b_xlin_ch15", xl_b[15*XW +: XW], 47);

    // Test 1: L=1. ch0 -> ((3+1)*2)*5+7 = 47, ch1 -> 0*10+9 = 9.
    set_ch_a(0, 3, 1, 2, 5, 7);
    set_ch_a(1, 10, 0, 1, 0, 9);
    cs = srdyo_cnt_a;
    start_frame_a(cap);
    check_eq("t1_busy_rise", busy_a, 1);
    wait_srdyo_a(100, edge_at);
    check_eq("t1_srdyo_cycle", 64'(edge_at - cap), 25);
    check_eq("t1_busy_in_done", busy_a, 0);
    check_eq("t1_xlin_ch0", xl_a[0*XW +: XW], 47);
    check_eq("t1_xlin_ch1", xl_a[1*XW +: XW], 9);
    repeat (5) @(negedge clk);
    check_eq("t1_srdyo_count", 64'(srdyo_cnt_a - cs), 1);
    check_eq("t1_overrun", ovr_a, 0);

    // Test 3: srdyi at cycle 10 of a running frame with changed data.
    start_frame_a(cap);
    repeat (9) @(negedge clk);
    srdyi_a = 1'b1;
    x_a[0*XW +: XW] = XW'(99);
    @(negedge clk);
    srdyi_a = 1'b0;
    check_eq("t3_overrun_set", ovr_a, 1);
    check_eq("t3_still_busy", busy_a, 1);
    wait_srdyo_a(100, edge_at);
    check_eq("t3_srdyo_cycle", 64'(edge_at - cap), 25);
    check_eq("t3_xlin_ch0", xl_a[0*XW +: XW], 47);
    check_eq("t3_xlin_ch1", xl_a[1*XW +: XW], 9);
    // Back-to-back frame: ch0 x=4 -> ((4+1)*2)*5+7 = 57.
    x_a[0*XW +: XW] = XW'(4);
    start_frame_a(cap);
    check_eq("t3b_busy_rise", busy_a, 1);
    wait_srdyo_a(100, edge_at);
    check_eq("t3b_srdyo_cycle", 64'(edge_at - cap), 25);
    check_eq("t3b_xlin_ch0", xl_a[0*XW +: XW], 57);
    check_eq("t3b_xlin_ch1", xl_a[1*XW +: XW], 9);
    check_eq("t3b_overrun_held", ovr_a, 1);

    // Test 4: reset in WAIT, late op_srdyo_i two cycles after.
    @(negedge clk);
    start_frame_a(cap);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (st_a == 2'd2) begin
        found = 1;
        break;
      end
    end
    check_eq("t4_reached_wait", 64'(found), 1);
    cs = srdyo_cnt_a;
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a  = 1'b0;
    spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    check_reset_a("t4");
    repeat (30) @(negedge clk);
    check_eq("t4_no_srdyo", 64'(srdyo_cnt_a - cs), 0);
    check_eq("t4_state_idle", st_a, 0);
    check_eq("t4_xlin_zero", xl_a, 0);

    // Test 5: spurious op_srdyo_i in IDLE, then variable-latency frame.
    spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    @(negedge clk);
    check_eq("t5_spur_state", st_a, 0);
    check_eq("t5_spur_busy", busy_a, 0);
    check_eq("t5_spur_xlin", xl_a, 0);
    lat_mode_a = 1;
    set_ch_a(0, 3, 1, 2, 5, 7);
    set_ch_a(1, 10, 0, 1, 0, 9);
    cs = srdyo_cnt_a;
    start_frame_a(cap);
    wait_srdyo_a(600, edge_at);
    check_eq("t5_done", 64'(edge_at > cap), 1);
    check_eq("t5_xlin_ch0", xl_a[0*XW +: XW], 47);
    check_eq("t5_xlin_ch1", xl_a[1*XW +: XW], 9);
    repeat (5) @(negedge clk);
    check_eq("t5_srdyo_count", 64'(srdyo_cnt_a - cs), 1);
    check_eq("a_operands_stable", 64'(stab_err_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nlc_horner_sequencer.md
Name: nlc_horner_sequencer

Overview:
Time-multiplexed nonlinearity-correction engine for NUM_CH ADC channels. It evaluates the polynomial of order ORDER for every channel through one shared arithmetic port. The arithmetic port is served externally by the fp_to_smc, smc_float multiplier, smc_float adder and smc_to_fp units. It generalises the 16-channel, 5th-order fixed NLC top to any channel count and any polynomial order. The handshake to the arithmetic units is fully sequenced, and input overrun is detected.

Parameters:
NUM_CH, 16, number of channels processed per frame (1..64)
ORDER, 5, polynomial order; ORDER+1 coefficients per channel (1..8)
XW, 21, fixed-point ADC/linearised sample width
FW, 32, smc float word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
srdyi  in  1  frame valid; captures all channel inputs
srdyo  out  1  one-cycle pulse: all x_lin_o valid
busy_o  out  1  frame in progress
overrun_o  out  1  sticky: srdyi seen while busy
x_adc_i  in  NUM_CH*XW  channel c at [c*XW +: XW]
recip_stdev_i  in  NUM_CH*FW  channel c at [c*FW +: FW]
neg_mean_i  in  NUM_CH*FW  channel c at [c*FW +: FW]
coeff_i  in  NUM_CH*(ORDER+1)*FW  coeff k of channel c at [(c*(ORDER+1)+k)*FW +: FW]
x_lin_o  out  NUM_CH*XW  linearised result, channel c at [c*XW +: XW]
op_code_o  out  2  00 fp_to_smc, 01 mul, 10 add, 11 smc_to_fp
op_a_o  out  FW  operand A; for fp_to_smc = zero-extended x_adc
op_b_o  out  FW  operand B; 0 for conversions
op_srdyi_o  out  1  one-cycle issue strobe to the arithmetic unit
op_z_i  in  FW  result; for smc_to_fp only [XW-1:0] is used
op_srdyo_i  in  1  result valid strobe from the arithmetic unit

Behaviour:
- Clock is clk; reset is synchronous and active-high. It is sampled only on the rising edge of clk.
- Reset values:
  - srdyo = 0, busy_o = 0, overrun_o = 0, op_srdyi_o = 0.
  - op_code_o, op_a_o and op_b_o = 0.
  - x_lin_o = 0.
  - FSM = IDLE; channel counter and step counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On srdyi = 1, register all inputs into an internal frame buffer and go to ISSUE with ch = 0, step = 0.
  - busy_o rises in the following cycle.
- Per-channel step sequence (4 + 2*ORDER ops):
  - step 0: xs = fp_to_smc(x_adc)
  - step 1: t = xs + neg_mean
  - step 2: t = t * recip_stdev
  - acc is initialised to coeff[ORDER]
  - for k = ORDER-1 down to 0: acc = acc * t, then acc = acc + coeff[k]
  - last step: x_lin[ch] = smc_to_fp(acc)
- ISSUE (exactly one cycle):
  - drive op_code_o, op_a_o and op_b_o, and pulse op_srdyi_o = 1;
  - then go to WAIT. Operands stay stable until op_srdyo_i.
- WAIT:
  - on op_srdyo_i, write op_z_i to the step destination (xs, t, acc or x_lin_o slice) and advance step;
  - at end of channel, set step = 0 and ch++;
  - if ch was NUM_CH-1, go to DONE, else go to ISSUE;
  - the next issue is the cycle after op_srdyo_i.
- DONE: srdyo = 1 for one cycle, busy_o = 0, return to IDLE. Back-to-back srdyi is accepted in the cycle after DONE.
- Timing: with unit latency L (op_srdyo_i L ≥ 1 cycles after op_srdyi_o), each op takes L+1 cycles. If srdyi is sampled at cycle 0, srdyo is at cycle NUM_CH*(4+2*ORDER)*(L+1)+1.
- x_lin_o slices update as each channel completes. All slices are guaranteed valid and held from the srdyo cycle until the next frame writes them.
- srdyi while not in IDLE: ignored (buffer untouched) and overrun_o is set. overrun_o is sticky and cleared only by reset.
- op_srdyo_i outside WAIT: ignored, no state change.
- Reset mid-frame: takes effect at the next edge and forces all reset values. Late op_srdyo_i pulses after reset are ignored.
- srdyi and reset in the same cycle: reset wins and the frame is not captured.

Test Plan:
1. Mock unit, integer semantics (conv = identity, add = sum, mul = low-32 product), L=1, NUM_CH=2, ORDER=1.
   - Stimulus: ch0 x=3, neg_mean=1, recip=2, c1=5, c0=7; ch1 x=10, neg_mean=0, recip=1, c1=0, c0=9.
   - Required: x_lin ch0=47, ch1=9; srdyo at cycle 25.
2. Defaults (16 ch, ORDER=5), mock L=3, srdyi at cycle 0 -> exactly one srdyo at cycle 897; 224 op_srdyi_o pulses; op_code sequence per channel 00,10,01,(01,10)x5,11.
3. srdyi pulsed at cycle 10 of a running frame -> overrun_o=1 and held, frame results unchanged. A second srdyi the cycle after srdyo -> new frame starts normally.
4. Reset asserted mid-WAIT with a late op_srdyo_i two cycles after -> all outputs at reset values, FSM IDLE, no srdyo, x_lin_o stays 0.
5. Mock with variable latency (1,5,2,7 cycling) -> results identical to test 1. Operands stable throughout each WAIT. Spurious op_srdyo_i in IDLE causes no change.
